// File: rtl/and_operand_loader.sv
// Nibble-serial operand loader for the 16-bit AND array: assembles a then b
// from a valid/ready nibble stream and holds both until op_ack.
// Optional abort input is enabled by defining LOADER_ABORT_EN.
`timescale 1ns/1ps

module and_operand_loader #(
    parameter int NIB_W  = 4,
    parameter int WORD_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NIB_W-1:0]  nib_in,
    input  logic              nib_valid,
    output logic              nib_ready,
    output logic [WORD_W-1:0] a,
    output logic [WORD_W-1:0] b,
    output logic              op_valid,
`ifdef LOADER_ABORT_EN
    input  logic              abort,
`endif
    input  logic              op_ack
);

    localparam int NIBS  = WORD_W / NIB_W;
    localparam int CNT_W = (NIBS > 1) ? $clog2(NIBS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIBS - 1);

    if ((WORD_W % NIB_W) != 0) begin : g_bad_width
        $error("WORD_W must be a multiple of NIB_W");
    end

    typedef enum logic [1:0] {
        LOAD_A  = 2'd0,
        LOAD_B  = 2'd1,
        PRESENT = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WORD_W-1:0] a_q, a_d;
    logic [WORD_W-1:0] b_q, b_d;
    logic              xfer;
    logic              last_nib;
    logic              abort_req;

`ifdef LOADER_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    assign xfer     = nib_valid & nib_ready;
    assign last_nib = (cnt_q == CNT_LAST);

    // NOTE: the operand registers are reset too, since a and b must read zero
    // straight out of reset; non-blocking updates keep every flop sampling
    // pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD_A;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    // NOTE: every signal gets a hold-value default first so no path through
    // the case statement can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        if (abort_req) begin
            // Abort restarts the load but leaves a/b contents untouched.
            state_d = LOAD_A;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                LOAD_A: begin
                    if (xfer) begin
                        a_d[cnt_q*NIB_W +: NIB_W] = nib_in;
                        if (last_nib) begin
                            state_d = LOAD_B;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                LOAD_B: begin
                    if (xfer) begin
                        b_d[cnt_q*NIB_W +: NIB_W] = nib_in;
                        if (last_nib) begin
                            state_d = PRESENT;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                PRESENT: begin
                    if (op_ack) begin
                        state_d = LOAD_A;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = LOAD_A;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        nib_ready = 1'b0;
        op_valid  = 1'b0;
        unique case (state_q)
            LOAD_A, LOAD_B: nib_ready = 1'b1;
            PRESENT:        op_valid  = 1'b1;
            default:        nib_ready = 1'b0;
        endcase
    end

    assign a = a_q;
    assign b = b_q;

endmodule

// File: tb/tb_and_operand_loader.sv
// Scoreboard bench for and_operand_loader: a driver pushes expected words,
// an independent monitor pops and compares whenever op_valid presents a pair.
`timescale 1ns/1ps

module tb_and_operand_loader;

    localparam int NIBS_TB = 4;

    typedef logic [3:0] nib8_t [8];
    typedef struct {
        logic [15:0] wa;
        logic [15:0] wb;
    } pair_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  nib_in;
    logic        nib_valid;
    logic        nib_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        op_valid;
    logic        op_ack;
`ifdef LOADER_ABORT_EN
    logic        abort;
`endif

    int    checks   = 0;
    int    failures = 0;
    int    cyc      = 0;
    pair_t exp_q[$];
    logic [15:0] last_b = 16'h0;

    and_operand_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .nib_in    (nib_in),
        .nib_valid (nib_valid),
        .nib_ready (nib_ready),
        .a         (a),
        .b         (b),
        .op_valid  (op_valid),
`ifdef LOADER_ABORT_EN
        .abort     (abort),
`endif
        .op_ack    (op_ack)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Word value of four nibbles, lowest first.
    function automatic logic [15:0] word_of(input logic [3:0] n0, input logic [3:0] n1,
                                            input logic [3:0] n2, input logic [3:0] n3);
        int w;
        w = int'(n0) + int'(n1) * 16 + int'(n2) * 256 + int'(n3) * 4096;
        return w[15:0];
    endfunction

    // Called at a negedge; returns at the negedge following the transfer edge.
    task automatic send_nib(input logic [3:0] d);
        nib_valid = 1'b1;
        nib_in    = d;
        check("ready_before_xfer", {31'b0, nib_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        nib_valid = 1'b0;
    endtask

    task automatic send_pair(input nib8_t n, input int max_gap);
        pair_t p;
        int    start;
        int    idle;
        int    g;
        p.wa = word_of(n[0], n[1], n[2], n[3]);
        p.wb = word_of(n[4], n[5], n[6], n[7]);
        exp_q.push_back(p);
        last_b = p.wb;
        start  = cyc;
        idle   = 0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0 && max_gap > 0) begin
                g = $urandom_range(0, max_gap);
                nib_valid = 1'b0;
                repeat (g) @(negedge clk);
                idle += g;
            end
            // Stray acks during loading must be ignored.
            op_ack = (i < 7) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (i == 7) check("op_valid_before_last", {31'b0, op_valid}, 32'd0);
            send_nib(n[i]);
        end
        op_ack = 1'b0;
        check("load_cycles", cyc - start, 2 * NIBS_TB + idle);
        check("op_valid_latency", {31'b0, op_valid}, 32'd1);
    endtask

    task automatic ack_pair(input int hold);
        repeat (hold) @(negedge clk);
        op_ack = 1'b1;
        @(negedge clk);
        op_ack = 1'b0;
        check("ack_op_valid", {31'b0, op_valid}, 32'd0);
        check("ack_nib_ready", {31'b0, nib_ready}, 32'd1);
    endtask

    // Monitor: compares each presented pair and checks it stays frozen.
    initial begin
        logic        prev_v;
        logic [15:0] hold_a, hold_b;
        pair_t       p;
        prev_v = 1'b0;
        hold_a = '0;
        hold_b = '0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && op_valid === 1'b1) begin
                if (!prev_v) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_pair actual a=%h b=%h required none", a, b);
                    end else begin
                        p = exp_q.pop_front();
                        check("pair_a", {16'b0, a}, {16'b0, p.wa});
                        check("pair_b", {16'b0, b}, {16'b0, p.wb});
                    end
                    hold_a = a;
                    hold_b = b;
                end else begin
                    check("held_a", {16'b0, a}, {16'b0, hold_a});
                    check("held_b", {16'b0, b}, {16'b0, hold_b});
                    check("held_ready", {31'b0, nib_ready}, 32'd0);
                end
            end
            prev_v = (rst_n === 1'b1) && (op_valid === 1'b1);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        nib8_t       n;
        logic [3:0]  part [6];
        logic [15:0] exp_a, exp_b;

        rst_n     = 1'b0;
        nib_in    = 4'h0;
        nib_valid = 1'b0;
        op_ack    = 1'b0;
`ifdef LOADER_ABORT_EN
        abort     = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("rst_a", {16'b0, a}, 32'h0);
        check("rst_b", {16'b0, b}, 32'h0);
        check("rst_op_valid", {31'b0, op_valid}, 32'd0);
        check("rst_nib_ready", {31'b0, nib_ready}, 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed first pair, back-to-back.
        n = '{4'h3, 4'hC, 4'hA, 4'hF, 4'h0, 4'hF, 4'hF, 4'h0};
        send_pair(n, 0);
        check("dir1_a", {16'b0, a}, 32'hFAC3);
        check("dir1_b", {16'b0, b}, 32'h0FF0);

        // Producer holds the next pair's first nibble while the consumer stalls.
        nib_valid = 1'b1;
        nib_in    = 4'h1;
        repeat (5) begin
            @(negedge clk);
            check("stall_ready", {31'b0, nib_ready}, 32'd0);
            check("stall_op_valid", {31'b0, op_valid}, 32'd1);
        end
        check("stall_a", {16'b0, a}, 32'hFAC3);
        check("stall_b", {16'b0, b}, 32'h0FF0);
        op_ack = 1'b1;
        @(negedge clk);
        op_ack = 1'b0;
        check("ack_op_valid", {31'b0, op_valid}, 32'd0);
        check("ack_nib_ready", {31'b0, nib_ready}, 32'd1);

        // The held nibble 1 must land exactly once, as a[3:0].
        n = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8};
        send_pair(n, 0);
        check("dir2_a", {16'b0, a}, 32'h4321);
        check("dir2_b", {16'b0, b}, 32'h8765);
        ack_pair(1);

        // Random pairs with random idle gaps and ack delays.
        for (int k = 0; k < 20; k++) begin
            for (int i = 0; i < 8; i++) n[i] = 4'($urandom_range(0, 15));
            send_pair(n, (k % 2 == 0) ? 3 : 0);
            ack_pair($urandom_range(0, 3));
        end

        // Reset after five nibbles discards the partial load at once.
        for (int i = 0; i < 5; i++) send_nib(4'($urandom_range(0, 15)));
        rst_n = 1'b0;
        #1;
        check("midrst_a", {16'b0, a}, 32'h0);
        check("midrst_b", {16'b0, b}, 32'h0);
        check("midrst_op_valid", {31'b0, op_valid}, 32'd0);
        check("midrst_nib_ready", {31'b0, nib_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        last_b = 16'h0;
        n = '{4'h9, 4'h8, 4'h7, 4'h6, 4'hE, 4'hD, 4'hC, 4'hB};
        send_pair(n, 2);
        check("postrst_a", {16'b0, a}, 32'h6789);
        check("postrst_b", {16'b0, b}, 32'hBCDE);
        ack_pair(0);

`ifdef LOADER_ABORT_EN
        // Abort after six nibbles: words keep partial contents, load restarts.
        for (int i = 0; i < 6; i++) begin
            part[i] = 4'($urandom_range(0, 15));
            send_nib(part[i]);
        end
        exp_a = word_of(part[0], part[1], part[2], part[3]);
        exp_b = word_of(part[4], part[5], 4'(last_b[11:8]), 4'(last_b[15:12]));
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_nib_ready", {31'b0, nib_ready}, 32'd1);
        check("abort_op_valid", {31'b0, op_valid}, 32'd0);
        check("abort_a_kept", {16'b0, a}, {16'b0, exp_a});
        check("abort_b_kept", {16'b0, b}, {16'b0, exp_b});
        for (int i = 0; i < 8; i++) n[i] = 4'($urandom_range(0, 15));
        send_pair(n, 1);
        ack_pair(1);
`else
        part  = '{default: 4'h0};
        exp_a = 16'h0;
        exp_b = 16'h0;
`endif

        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
